// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator at the head of the video path. It walks a pixel
// counter (hpos) across each line and a line counter (vpos) down each frame,
// and from those positions produces the sync pulses, the active-video
// qualifier, per-line / per-frame tick pulses and a free-running frame count
// used for animation. Downstream overlay stages consume hpos[8:0]/vpos[8:0]
// combinationally as their x/y, so every output here is aligned to the
// hpos/vpos presented in the same cycle.
//
// Default timing is 640x480 @ 60 Hz on a 25.175 MHz pixel clock
// (800 x 525 total, 420 000 clocks per frame).
//
// Ports
//   clk          in   1   pixel clock, the only clock
//   reset        in   1   synchronous, active-high reset
//   ce           in   1   pixel enable; state advances only when high
//   hpos         out 10   current column, 0 .. H_TOTAL-1
//   vpos         out 10   current line,   0 .. V_TOTAL-1
//   hsync        out  1   horizontal sync, equal to SYNC_POL while asserted
//   vsync        out  1   vertical sync,   equal to SYNC_POL while asserted
//   display_on   out  1   high while hpos < H_ACTIVE and vpos < V_ACTIVE
//   line_tick    out  1   one-clock pulse in the first cycle of every line
//   frame_tick   out  1   one-clock pulse in the first cycle of every frame
//   frame_count  out  8   frames elapsed since reset, modulo 256
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  // Derived raster geometry. Totals must not exceed 1024 so that the last
  // position on a line/frame still fits the 10-bit counters.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VISIBLE    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       v_wrap;
  logic       hsync_next;
  logic       vsync_next;
  logic       display_next;

  // Next raster position. The output registers are loaded from this decode
  // rather than from the current counters, which is what keeps every output
  // aligned with the hpos/vpos shown in the same cycle without adding a
  // combinational path from the counters to the pins. vpos only moves on the
  // cycle hpos wraps, so vsync can only ever change at the start of a line.
  always_comb begin
    h_wrap = (hpos == H_LAST);
    v_wrap = h_wrap && (vpos == V_LAST);

    h_next = h_wrap ? 10'd0 : hpos + 10'd1;

    if (v_wrap) begin
      v_next = 10'd0;
    end else if (h_wrap) begin
      v_next = vpos + 10'd1;
    end else begin
      v_next = vpos;
    end

    hsync_next   = (h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST);
    vsync_next   = (v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST);
    display_next = (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
  end

  // Counter and output registers. Reset wins over ce and drops any sync
  // pulse in progress immediately; the reset state is the decode of (0,0)
  // but without ticks, so leaving reset never looks like a wrap. On ce=0
  // cycles the counters and level outputs hold while the ticks are forced
  // low, so a tick is one clock wide regardless of the pixel rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= 10'd0;
      vpos        <= 10'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b1;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= 8'd0;
    end else if (ce) begin
      hpos        <= h_next;
      vpos        <= v_next;
      hsync       <= hsync_next ? SYNC_POL : ~SYNC_POL;
      vsync       <= vsync_next ? SYNC_POL : ~SYNC_POL;
      display_on  <= display_next;
      line_tick   <= h_wrap;
      frame_tick  <= v_wrap;
      if (v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end else begin
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Instance dut_a uses the default
// 640x480 timing (active-low sync) for reset, line timing and ce toggling.
// Instance dut_b uses a tiny 16x12 raster with active-high sync so that whole
// frames, a mid-sync reset and the 256-frame counter wrap fit in a short run.
//
// dut_b geometry: H 8+2+3+3 = 16 (hsync on hpos 10..12),
//                 V 6+2+2+2 = 12 (vsync on vpos 8..9), 192 clocks per frame.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset_a, ce_a, reset_b, ce_b;
  logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic       hsync_a, vsync_a, display_on_a, line_tick_a, frame_tick_a;
  logic       hsync_b, vsync_b, display_on_b, line_tick_b, frame_tick_b;
  logic [7:0] frame_count_a, frame_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk         (clk),
    .reset       (reset_a),
    .ce          (ce_a),
    .hpos        (hpos_a),
    .vpos        (vpos_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .display_on  (display_on_a),
    .line_tick   (line_tick_a),
    .frame_tick  (frame_tick_a),
    .frame_count (frame_count_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .SYNC_POL (1'b1)
  ) dut_b (
    .clk         (clk),
    .reset       (reset_b),
    .ce          (ce_b),
    .hpos        (hpos_b),
    .vpos        (vpos_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .display_on  (display_on_b),
    .line_tick   (line_tick_b),
    .frame_tick  (frame_tick_b),
    .frame_count (frame_count_b)
  );

  // Drive both instances for exactly one rising edge; returns on the
  // following falling edge so outputs are sampled well away from the clock.
  task automatic applyStimulus(input logic rst_a_v, input logic ce_a_v,
                               input logic rst_b_v, input logic ce_b_v);
    reset_a = rst_a_v;
    ce_a    = ce_a_v;
    reset_b = rst_b_v;
    ce_b    = ce_b_v;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int hs_low, hs_first, hs_last, disp_bad, tick_bad, pos_bad, vs_bad;
    int exp_h, exp_v, lt_count, lt_double, hold_bad;
    logic ce_v, prev_lt;
    int ft_count, ft_first, ft_second, lt_frame, vs_count, vs_first;
    int hs_count, disp_count, fc_at_first;
    int fc255, fc256, ft256_n, fc_before, fc_change_bad;
    logic [7:0] prev_fc;

    $display("[TB] start");

    // ---------------- Reset hold (both instances) ----------------
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("a_rst_hpos", hpos_a, 0);
    checkOutput("a_rst_vpos", vpos_a, 0);
    checkOutput("a_rst_hsync", hsync_a, 1);
    checkOutput("a_rst_vsync", vsync_a, 1);
    checkOutput("a_rst_display_on", display_on_a, 1);
    checkOutput("a_rst_line_tick", line_tick_a, 0);
    checkOutput("a_rst_frame_tick", frame_tick_a, 0);
    checkOutput("a_rst_frame_count", frame_count_a, 0);
    checkOutput("b_rst_hsync", hsync_b, 0);
    checkOutput("b_rst_vsync", vsync_b, 0);
    checkOutput("b_rst_display_on", display_on_b, 1);

    // ---------------- Release A ----------------
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("a_rel_hpos", hpos_a, 1);
    checkOutput("a_rel_vpos", vpos_a, 0);
    checkOutput("a_rel_line_tick", line_tick_a, 0);
    checkOutput("a_rel_frame_tick", frame_tick_a, 0);
    checkOutput("a_rel_display_on", display_on_a, 1);

    // ---------------- Line 0 timing on A ----------------
    hs_low = 0; hs_first = -1; hs_last = -1;
    disp_bad = 0; tick_bad = 0; pos_bad = 0; vs_bad = 0;
    for (int i = 2; i <= 799; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      if (hpos_a !== 10'(i) || vpos_a !== 10'd0) pos_bad++;
      if (hsync_a === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (display_on_a !== (i < 640)) disp_bad++;
      if (line_tick_a !== 1'b0 || frame_tick_a !== 1'b0) tick_bad++;
      if (vsync_a !== 1'b1) vs_bad++;
    end
    checkOutput("a_line_pos", pos_bad, 0);
    checkOutput("a_hsync_width", hs_low, 96);
    checkOutput("a_hsync_first", hs_first, 656);
    checkOutput("a_hsync_last", hs_last, 751);
    checkOutput("a_display_decode", disp_bad, 0);
    checkOutput("a_no_tick_midline", tick_bad, 0);
    checkOutput("a_vsync_idle", vs_bad, 0);

    // Wrap 799 -> 0
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("a_wrap_hpos", hpos_a, 0);
    checkOutput("a_wrap_vpos", vpos_a, 1);
    checkOutput("a_wrap_line_tick", line_tick_a, 1);
    checkOutput("a_wrap_frame_tick", frame_tick_a, 0);
    checkOutput("a_wrap_display_on", display_on_a, 1);
    checkOutput("a_wrap_hsync", hsync_a, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("a_after_wrap_hpos", hpos_a, 1);
    checkOutput("a_after_wrap_line_tick", line_tick_a, 0);

    // ---------------- ce every 2nd cycle on A ----------------
    exp_h = 1; exp_v = 1; lt_count = 0; lt_double = 0; hold_bad = 0;
    prev_lt = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      ce_v = (i % 2 == 0);
      applyStimulus(1'b0, ce_v, 1'b1, 1'b1);
      if (ce_v) begin
        if (exp_h == 799) begin
          exp_h = 0;
          exp_v = exp_v + 1;
        end else begin
          exp_h = exp_h + 1;
        end
      end
      if (hpos_a !== 10'(exp_h) || vpos_a !== 10'(exp_v)) hold_bad++;
      if (display_on_a !== (exp_h < 640)) hold_bad++;
      if (line_tick_a === 1'b1) begin
        lt_count++;
        if (prev_lt === 1'b1) lt_double++;
      end
      prev_lt = line_tick_a;
    end
    checkOutput("a_ce_hold_track", hold_bad, 0);
    checkOutput("a_ce_line_ticks", lt_count, 1);
    checkOutput("a_ce_tick_width", lt_double, 0);
    checkOutput("a_ce_end_hpos", hpos_a, 1);
    checkOutput("a_ce_end_vpos", vpos_a, 2);

    // ---------------- B: two full frames ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("b_rel_hpos", hpos_b, 1);
    checkOutput("b_rel_tick", line_tick_b | frame_tick_b, 0);
    ft_count = 0; ft_first = -1; ft_second = -1; lt_frame = 0;
    vs_count = 0; vs_first = -1; hs_count = 0; disp_count = 1; fc_at_first = -1;
    for (int n = 2; n <= 384; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      if (frame_tick_b === 1'b1) begin
        ft_count++;
        if (ft_first < 0) begin
          ft_first = n;
          fc_at_first = frame_count_b;
        end else if (ft_second < 0) begin
          ft_second = n;
        end
      end
      if (n <= 192) begin
        if (line_tick_b === 1'b1) lt_frame++;
        if (vsync_b === 1'b1) begin
          vs_count++;
          if (vs_first < 0) vs_first = n;
        end
        if (hsync_b === 1'b1) hs_count++;
        if (display_on_b === 1'b1) disp_count++;
      end
    end
    checkOutput("b_frame_ticks", ft_count, 2);
    checkOutput("b_first_frame_tick", ft_first, 192);
    checkOutput("b_frame_period", ft_second - ft_first, 192);
    checkOutput("b_fc_at_first_tick", fc_at_first, 1);
    checkOutput("b_line_ticks_per_frame", lt_frame, 12);
    checkOutput("b_vsync_cycles", vs_count, 32);
    checkOutput("b_vsync_first", vs_first, 128);
    checkOutput("b_hsync_cycles", hs_count, 36);
    checkOutput("b_display_cycles", disp_count, 48);
    checkOutput("b_fc_two_frames", frame_count_b, 2);
    checkOutput("b_frame_end_hpos", hpos_b, 0);
    checkOutput("b_frame_end_vpos", vpos_b, 0);

    // ---------------- B: reset inside both sync pulses ----------------
    repeat (155) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("b_pre_rst_hpos", hpos_b, 11);
    checkOutput("b_pre_rst_vpos", vpos_b, 9);
    checkOutput("b_pre_rst_hsync", hsync_b, 1);
    checkOutput("b_pre_rst_vsync", vsync_b, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("b_mid_rst_hpos", hpos_b, 0);
    checkOutput("b_mid_rst_vpos", vpos_b, 0);
    checkOutput("b_mid_rst_hsync", hsync_b, 0);
    checkOutput("b_mid_rst_vsync", vsync_b, 0);
    checkOutput("b_mid_rst_ticks", line_tick_b | frame_tick_b, 0);
    checkOutput("b_mid_rst_fc", frame_count_b, 0);
    checkOutput("b_mid_rst_display_on", display_on_b, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("b_rel2_hpos", hpos_b, 1);
    checkOutput("b_rel2_ticks", line_tick_b | frame_tick_b, 0);

    // ---------------- B: 256 frames, frame_count wrap ----------------
    ft_count = 0; fc255 = -1; fc256 = -1; ft256_n = -1; fc_before = -1;
    fc_change_bad = 0;
    prev_fc = frame_count_b;
    for (int n = 2; n <= 256 * 192; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      if (frame_tick_b === 1'b1) begin
        ft_count++;
        if (ft_count == 255) fc255 = frame_count_b;
        if (ft_count == 256) begin
          fc256     = frame_count_b;
          ft256_n   = n;
          fc_before = prev_fc;
        end
      end else if (frame_count_b !== prev_fc) begin
        fc_change_bad++;
      end
      prev_fc = frame_count_b;
    end
    checkOutput("b_wrap_tick_count", ft_count, 256);
    checkOutput("b_wrap_fc_255", fc255, 255);
    checkOutput("b_wrap_fc_before", fc_before, 255);
    checkOutput("b_wrap_fc_0", fc256, 0);
    checkOutput("b_wrap_tick_time", ft256_n, 256 * 192);
    checkOutput("b_fc_change_only_on_tick", fc_change_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that drives the video pipeline: produces the pixel coordinates consumed by the text and graphics overlay stages, plus horizontal/vertical sync, the active-video qualifier and a frame counter for animation. Sits at the head of the video path, directly upstream of the overlay/text stages and the RGB mixer. Default timing is 640x480 at 60 Hz on a 25.175 MHz pixel clock. Overlay stages take `hpos[8:0]` / `vpos[8:0]` as their `x` / `y`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- `clk` input 1: pixel clock. This is the only clock.
- `reset` input 1: synchronous, active-high reset.
- `ce` input 1: pixel enable. State advances only on cycles where `ce`=1.
- `hpos` output 10: current column, 0..H_TOTAL-1
- `vpos` output 10: current line, 0..V_TOTAL-1
- `hsync` output 1: horizontal sync, at level SYNC_POL when asserted
- `vsync` output 1: vertical sync, at level SYNC_POL when asserted
- `display_on` output 1: high when `hpos` < H_ACTIVE and `vpos` < V_ACTIVE
- `line_tick` output 1: one-cycle pulse at the start of every line
- `frame_tick` output 1: one-cycle pulse at the start of every frame
- `frame_count` output 8: frames elapsed since reset, modulo 256

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤ 1024. Counters are 10-bit unsigned.
- **Horizontal counter.** On a `ce`=1 cycle, `hpos` increments. If `hpos` = H_TOTAL-1, it wraps to 0 instead.
- **Vertical counter.** `vpos` increments only on the cycle where `hpos` wraps. If `vpos` = V_TOTAL-1 at that point, it wraps to 0.
- **hsync asserted** for `hpos` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Default range is 656..751.
- **vsync asserted** for `vpos` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Default range is 490..491. vsync spans whole lines and changes only at `hpos` = 0.
- **Deasserted sync level** is ~SYNC_POL.
- **Registered outputs.** `hsync`, `vsync`, `display_on`, `line_tick` and `frame_tick` are registers. They are computed from the next-state counter values, so every output always describes the `hpos`/`vpos` presented in the same cycle. No combinational path runs from counters to outputs.
- **line_tick** = 1 in the cycle where `hpos` has just become 0 by wrap.
- **frame_tick** = 1 in the cycle where `hpos` and `vpos` have both just become 0 by wrap.
- **frame_count** increments on that same wrap, going 255 → 0. The new value is visible in the same cycle as `frame_tick`.
- **`ce`=0 cycles:** all counters and level outputs hold. `line_tick` and `frame_tick` are 0, so each tick lasts exactly one clock even at reduced pixel rate.
- **Reset** (sampled on a `clk` edge with `reset`=1) loads:
  - `hpos`=0, `vpos`=0, `frame_count`=0
  - `hsync`=`vsync`=~SYNC_POL
  - `display_on`=1 (the decode of (0,0))
  - `line_tick`=0, `frame_tick`=0
- **Reset priority:**
  - `reset` takes priority over `ce`.
  - Reset asserted mid-frame or mid-sync aborts immediately; no partial pulse completes.
  - Leaving reset does not generate `frame_tick` or `line_tick`. The first ticks occur at the first natural wrap.

## Timing
- First edge with `reset`=0 and `ce`=1 gives `hpos`=1, `vpos`=0.
- With `ce` tied high, the line period is H_TOTAL clocks and the frame period is H_TOTAL×V_TOTAL clocks (420 000 at defaults).
- `display_on` falls in the same cycle `hpos` becomes H_ACTIVE, and rises in the same cycle `hpos` returns to 0 on a visible line.
- hsync assertion and deassertion edges coincide exactly with the `hpos` values above.
- `vpos` changes in the same cycle `hpos` becomes 0.
- Downstream overlay stages are combinational on `hpos`/`vpos`. Any stage that adds a register delay must delay the sync signals by the same number of cycles.

## Test plan
- **Reset hold and release:**
  - Stimulus: `reset`=1 for 5 cycles with `ce`=1.
  - Response: `hpos`=`vpos`=0, `hsync`=`vsync`=1, `display_on`=1, ticks 0, `frame_count`=0.
  - Stimulus: release reset.
  - Response: next cycle `hpos`=1, with no tick.
- **Line timing (`ce`=1):**
  - `hsync` low for exactly 96 cycles, starting at `hpos`=656.
  - `display_on` low on `hpos` 640..799.
  - `hpos` 799 → 0 with `vpos`+1 and `line_tick`=1 for one cycle.
- **Frame timing:**
  - `vsync` low exactly on lines 490–491, i.e. 1600 cycles.
  - At 799/524 → 0/0, `frame_tick`=1 for one cycle and `frame_count` 0 → 1.
  - Consecutive `frame_tick`s are 420 000 cycles apart.
- **`ce` toggling:**
  - Stimulus: `ce`=1 every 2nd cycle.
  - Response: all periods double. Each tick is high for exactly one clock. Outputs hold on `ce`=0 cycles.
- **Mid-operation reset:**
  - Stimulus: assert `reset` at `hpos`=700, `vpos`=491 (inside both sync pulses).
  - Response: the next cycle shows `hsync`=`vsync`=1, `hpos`=`vpos`=0 and no tick.
- **Wrap:**
  - Stimulus: run 256 frames (force counters near the end to shorten the run).
  - Response: `frame_count` 255 → 0 coincident with `frame_tick`.
